// File: rtl/bs_pkg.sv
// Shared types and helpers for the Battleship master board: FSM states,
// slave status codes, fleet size and a 16-bit popcount.
package bs_pkg;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    A_LD  = 3'd1,
    A_ATK = 3'd2,
    B_LD  = 3'd3,
    B_ATK = 3'd4,
    A_WIN = 3'd5,
    B_WIN = 3'd6
  } state_t;

  localparam logic [2:0] DISP_LOAD  = 3'd0;
  localparam logic [2:0] DISP_A     = 3'd1;
  localparam logic [2:0] DISP_B     = 3'd2;
  localparam logic [2:0] DISP_A_WIN = 3'd3;
  localparam logic [2:0] DISP_B_WIN = 3'd4;

  localparam int SHIP_CELLS = 7;

  // Display glyph: {blank, hex nibble}
  localparam logic [4:0] GLYPH_BLANK = 5'b10000;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/bs_seg_mux.sv
// Time-multiplexed 4-digit 7-segment driver: refresh counter, digit select
// and hex decoding into active-low cathodes (seg[7] is the decimal point).
module bs_seg_mux #(
  parameter int REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] dig3,
  input  logic [4:0] dig2,
  input  logic [4:0] dig1,
  input  logic [4:0] dig0,
  output logic [7:0] seg,
  output logic [3:0] an
);

  logic [REFRESH_BITS-1:0] cnt;
  logic [1:0]              sel;
  logic [4:0]              glyph;

  assign sel = cnt[REFRESH_BITS-1 -: 2];

  always_comb begin
    glyph = dig0;
    case (sel)
      2'd3:    glyph = dig3;
      2'd2:    glyph = dig2;
      2'd1:    glyph = dig1;
      default: glyph = dig0;
    endcase
  end

  function automatic logic [7:0] decode(input logic [4:0] g);
    logic [7:0] s;
    s = 8'hFF;
    if (!g[4]) begin
      case (g[3:0])
        4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
        4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
        4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
        4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
      endcase
    end
    return s;
  endfunction

  // Registered outputs so a reset blanks the display for a full cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      seg <= 8'hFF;
      an  <= 4'b1111;
    end else begin
      cnt <= cnt + 1'b1;
      seg <= decode(glyph);
      an  <= ~(4'b0001 << sel);
    end
  end

endmodule

// File: rtl/bs_master_top.sv
// Battleship master board: latches both fleets, sequences the A/B turns,
// decides the winner and drives the local display and the slave link.
module bs_master_top
  import bs_pkg::*;
#(
  parameter int REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        BTN3A,
  input  logic        BTN3B,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        BTN1A,
  input  logic        BTN1B,
  input  logic        BTN2A,
  input  logic        BTN2B,
  input  logic        OKB,
  input  logic        LivB,
  output logic        clr,
  output logic [15:0] A_Attack,
  output logic        UART_Activate,
  output logic        ST,
  output logic        LDR1B,
  output logic        LDR2B,
  output logic [2:0]  DispB,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic [2:0]  dbg_state
);

  // Handshake: there is no back-pressure on the slave link; UART_Activate is a
  // one-cycle valid strobe and A_Attack/DispB are stable while it is high.

  state_t      state, state_nx;
  logic [15:0] ship_a, ship_b, att_a, att_b;
  logic        rst, oka, a_move_ok;
  logic [4:0]  hits_a, hits_b, a_new_cnt;
  logic [4:0]  dig3, dig1, dig0;

  assign rst       = BTN3A | BTN3B;
  assign oka       = (popcount16(A) == 5'(SHIP_CELLS));
  assign a_new_cnt = popcount16(A & ~att_a);
  assign a_move_ok = (a_new_cnt == 5'd1) && ((att_a & ~A) == 16'd0);

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:  if (BTN1A && BTN1B && oka && OKB) state_nx = A_LD;
      A_LD:  if (BTN2A && a_move_ok) state_nx = A_ATK;
      A_ATK: state_nx = (((att_a & ship_b) == ship_b) || !LivB) ? A_WIN : B_LD;
      B_LD:  if (BTN2B && OKB) state_nx = B_ATK;
      B_ATK: state_nx = ((att_b & ship_a) == ship_a) ? B_WIN : A_LD;
      A_WIN: state_nx = A_WIN;
      B_WIN: state_nx = B_WIN;
      default: state_nx = LOAD;
    endcase
  end

  // The attack map is captured on the fire edge so that it is already on
  // A_Attack (and in the win check) during the one-cycle ATK state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      ship_a <= '0;
      ship_b <= '0;
      att_a  <= '0;
      att_b  <= '0;
    end else begin
      state <= state_nx;
      if (state == LOAD && state_nx == A_LD) begin
        ship_a <= A;
        ship_b <= B;
        att_a  <= '0;
        att_b  <= '0;
      end
      if (state == A_LD && state_nx == A_ATK) att_a <= A;
      if (state == B_LD && state_nx == B_ATK) att_b <= B;
    end
  end

  assign clr           = rst;
  assign A_Attack      = att_a;
  assign UART_Activate = ((state == A_ATK) || (state == B_ATK)) && !rst;
  assign ST            = (state != LOAD);
  assign LDR1B         = (state == B_LD);
  assign LDR2B         = (state == A_LD);
  assign dbg_state     = state;

  always_comb begin
    DispB = DISP_LOAD;
    dig3  = GLYPH_BLANK;
    case (state)
      A_LD, A_ATK: begin DispB = DISP_A;     dig3 = 5'h0A; end
      B_LD, B_ATK: begin DispB = DISP_B;     dig3 = 5'h0B; end
      A_WIN:       begin DispB = DISP_A_WIN; dig3 = 5'h0A; end
      B_WIN:       begin DispB = DISP_B_WIN; dig3 = 5'h0B; end
      default:     begin DispB = DISP_LOAD;  dig3 = GLYPH_BLANK; end
    endcase
  end

  // Hit counts cannot exceed one hex digit with a legal fleet; saturate anyway.
  assign hits_a = popcount16(att_a & ship_b);
  assign hits_b = popcount16(att_b & ship_a);
  assign dig1   = {1'b0, hits_a[4] ? 4'hF : hits_a[3:0]};
  assign dig0   = {1'b0, hits_b[4] ? 4'hF : hits_b[3:0]};

  bs_seg_mux #(.REFRESH_BITS(REFRESH_BITS)) u_seg_mux (
    .clk  (clk),
    .rst  (rst),
    .dig3 (dig3),
    .dig2 (GLYPH_BLANK),
    .dig1 (dig1),
    .dig0 (dig0),
    .seg  (seg),
    .an   (an)
  );

endmodule

// File: tb/tb_bs_master_top.sv
// Randomised game-level bench for bs_master_top with a turn-based game model
// and a scoreboard on the slave-link transfer strobe.
module tb_bs_master_top;
  import bs_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        BTN3A, BTN3B, BTN1A, BTN1B, BTN2A, BTN2B, OKB, LivB;
  logic [15:0] A, B;
  logic        clr, UART_Activate, ST, LDR1B, LDR2B;
  logic [15:0] A_Attack;
  logic [2:0]  DispB, dbg_state;
  logic [7:0]  seg;
  logic [3:0]  an;

  bs_master_top #(.REFRESH_BITS(4)) dut (
    .clk(clk), .BTN3A(BTN3A), .BTN3B(BTN3B), .A(A), .B(B),
    .BTN1A(BTN1A), .BTN1B(BTN1B), .BTN2A(BTN2A), .BTN2B(BTN2B),
    .OKB(OKB), .LivB(LivB), .clr(clr), .A_Attack(A_Attack),
    .UART_Activate(UART_Activate), .ST(ST), .LDR1B(LDR1B), .LDR2B(LDR2B),
    .DispB(DispB), .seg(seg), .an(an), .dbg_state(dbg_state)
  );

  logic [18:0] exp_q[$];
  logic [18:0] mon_e;
  int vectors = 0;
  int miscompares = 0;

  // Game model: fleets, cumulative maps, phase 0 load/1 A turn/2 B turn/3 A won/4 B won
  logic [15:0] ship_a, ship_b, att_a, att_b;
  int phase;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int pc(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic logic [15:0] pick_bit(input logic [15:0] allowed);
    int k;
    logic [15:0] r = 16'd0;
    if (allowed == 16'd0) return 16'd0;
    k = $urandom_range(pc(allowed) - 1, 0);
    for (int i = 0; i < 16; i++) begin
      if (allowed[i]) begin
        if (k == 0 && r == 16'd0) r = 16'(1) << i;
        k--;
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_fleet();
    logic [15:0] v = 16'd0;
    while (pc(v) < 7) v = v | (16'(1) << $urandom_range(15, 0));
    return v;
  endfunction

  function automatic logic [7:0] hex_glyph(input int h);
    case (h)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [2:0] exp_state(input int p);
    case (p)
      1: return 3'(A_LD);
      2: return 3'(B_LD);
      3: return 3'(A_WIN);
      4: return 3'(B_WIN);
      default: return 3'(LOAD);
    endcase
  endfunction

  // Slave-link monitor: every transfer strobe must match the next expected item.
  always @(negedge clk) begin
    if (UART_Activate === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL uart_unexpected: got A_Attack=%h DispB=%0d expected no transfer", A_Attack, DispB);
      end else begin
        mon_e = exp_q.pop_front();
        check("uart_xfer", 32'({A_Attack, DispB}), 32'(mon_e));
      end
    end
  end

  task automatic check_status(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(exp_state(phase)));
    check({tag, "_st"},    32'(ST),        32'(phase != 0));
    check({tag, "_dispb"}, 32'(DispB),     32'(phase));
    check({tag, "_ldr1b"}, 32'(LDR1B),     32'(phase == 2));
    check({tag, "_ldr2b"}, 32'(LDR2B),     32'(phase == 1));
    check({tag, "_att"},   32'(A_Attack),  32'(att_a));
    check({tag, "_uart"},  32'(UART_Activate), 32'd0);
  endtask

  task automatic check_disp(input string tag);
    logic [7:0] want;
    logic [3:0] target;
    for (int d = 0; d < 4; d++) begin
      target = ~(4'b0001 << d);
      case (d)
        0: want = hex_glyph(pc(att_b & ship_a));
        1: want = hex_glyph(pc(att_a & ship_b));
        2: want = 8'hFF;
        default: want = (phase == 0) ? 8'hFF : ((phase == 1 || phase == 3) ? 8'h88 : 8'h83);
      endcase
      for (int k = 0; k < 40 && an !== target; k++) cyc();
      if (an !== target) begin
        vectors++;
        miscompares++;
        $display("FAIL %s_scan_timeout: got an=%b expected %b", tag, an, target);
      end else begin
        check({tag, "_seg"}, 32'(seg), 32'(want));
      end
    end
  endtask

  task automatic do_reset(input logic ra, input logic rb);
    BTN3A = ra; BTN3B = rb;
    cyc();
    phase = 0; att_a = 16'd0; att_b = 16'd0; ship_a = 16'd0; ship_b = 16'd0;
    check("rst_clr", 32'(clr), 32'd1);
    check("rst_an",  32'(an),  32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check_status("rst");
    BTN3A = 1'b0; BTN3B = 1'b0;
    cyc();
    check("rst_clr_release", 32'(clr), 32'd0);
  endtask

  task automatic load_game(input logic [15:0] sa, input logic [15:0] sb);
    A = sa; B = sb; OKB = (pc(sb) == 7);
    BTN1A = 1'b1; BTN1B = 1'b1;
    cyc();
    BTN1A = 1'b0; BTN1B = 1'b0; OKB = 1'b0;
    if (pc(sa) == 7 && pc(sb) == 7) begin
      ship_a = sa; ship_b = sb; att_a = 16'd0; att_b = 16'd0; phase = 1;
    end
    check_status("load");
  endtask

  task automatic fire_a(input logic [15:0] map);
    logic legal, wins;
    legal = (pc(map & ~att_a) == 1) && ((att_a & ~map) == 16'd0);
    A = map; BTN2A = 1'b1;
    if (legal) exp_q.push_back({map, 3'd1});
    cyc();
    BTN2A = 1'b0;
    if (legal) begin
      att_a = map;
      check("a_atk_state", 32'(dbg_state), 32'(A_ATK));
      check("a_atk_uart",  32'(UART_Activate), 32'd1);
      check("a_atk_map",   32'(A_Attack), 32'(map));
      wins = ((att_a & ship_b) == ship_b) || !LivB;
      cyc();
      phase = wins ? 3 : 2;
    end
    check_status("a_fire");
  endtask

  task automatic fire_b(input logic [15:0] map);
    logic legal, wins;
    legal = (pc(map & ~att_b) == 1) && ((att_b & ~map) == 16'd0);
    B = map; OKB = legal; BTN2B = 1'b1;
    if (legal) exp_q.push_back({att_a, 3'd2});
    cyc();
    BTN2B = 1'b0; OKB = 1'b0;
    if (legal) begin
      att_b = map;
      check("b_atk_state", 32'(dbg_state), 32'(B_ATK));
      check("b_atk_uart",  32'(UART_Activate), 32'd1);
      wins = ((att_b & ship_a) == ship_a);
      cyc();
      phase = wins ? 4 : 1;
    end
    check_status("b_fire");
  endtask

  function automatic logic [15:0] illegal_a();
    logic [15:0] x, y;
    x = pick_bit(~att_a);
    y = pick_bit(~att_a & ~x);
    return att_a | x | y;
  endfunction

  function automatic logic [15:0] illegal_b();
    if (att_b != 16'd0) return (att_b & ~pick_bit(att_b)) | pick_bit(~att_b);
    return 16'h0003;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    A = 16'd0; B = 16'd0; BTN1A = 0; BTN1B = 0; BTN2A = 0; BTN2B = 0;
    BTN3A = 0; BTN3B = 0; OKB = 0; LivB = 1;
    phase = 0; ship_a = 0; ship_b = 0; att_a = 0; att_b = 0;

    do_reset(1'b1, 1'b0);
    check_status("idle");

    // Incomplete load requests are ignored
    A = 16'hE606; B = 16'h30E6; OKB = 1'b1; BTN1A = 1'b1; BTN1B = 1'b0;
    cyc();
    BTN1A = 1'b0; OKB = 1'b0;
    check_status("load_one_btn");
    load_game(16'h003F, 16'h30E6);

    // Game 1: B sinks A's fleet
    load_game(16'hE606, 16'h30E6);
    check_disp("g1_start");
    fire_a(16'h8000);
    fire_b(att_b | pick_bit(ship_a & ~att_b));
    fire_a(16'hC002);
    B = 16'hFFFF; OKB = 1'b1; BTN2B = 1'b1;
    cyc();
    BTN2B = 1'b0; OKB = 1'b0;
    check_status("b_out_of_turn");
    for (int it = 0; it < 40 && (phase == 1 || phase == 2); it++) begin
      if (phase == 1) begin
        if ($urandom_range(1, 0) == 1) fire_a(illegal_a());
        fire_a(att_a | pick_bit(~ship_b & ~att_a));
      end else begin
        if ($urandom_range(1, 0) == 1) fire_b(illegal_b());
        fire_b(att_b | pick_bit(ship_a & ~att_b));
      end
    end
    check("g1_winner", 32'(phase), 32'd4);
    check_disp("g1_end");
    A = $urandom_range(16'hFFFF, 0); BTN2A = 1; BTN2B = 1; BTN1A = 1; BTN1B = 1; OKB = 1;
    cyc(); cyc(); cyc();
    BTN2A = 0; BTN2B = 0; BTN1A = 0; BTN1B = 0; OKB = 0;
    check_status("g1_terminal");
    do_reset(1'b1, 1'b1);

    // Game 2: A wins because the slave reports B sunk
    load_game(rand_fleet(), rand_fleet());
    for (int r = 0; r < 3; r++) begin
      fire_a(att_a | pick_bit(~ship_b & ~att_a));
      fire_b(att_b | pick_bit(~ship_a & ~att_b));
    end
    LivB = 1'b0;
    fire_a(att_a | pick_bit(~ship_b & ~att_a));
    LivB = 1'b1;
    check("g2_winner", 32'(phase), 32'd3);
    check_disp("g2_end");
    do_reset(1'b0, 1'b1);

    // Game 3: reset during an attack, then A sinks B outright
    load_game(rand_fleet(), rand_fleet());
    A = pick_bit(16'hFFFF); BTN2A = 1'b1;
    cyc();
    BTN2A = 1'b0;
    check("mid_atk_state", 32'(dbg_state), 32'(A_ATK));
    BTN3A = 1'b1;
    #1;
    check("mid_atk_uart_gated", 32'(UART_Activate), 32'd0);
    cyc();
    BTN3A = 1'b0;
    phase = 0; att_a = 0; att_b = 0; ship_a = 0; ship_b = 0;
    check_status("mid_atk_reset");
    load_game(rand_fleet(), rand_fleet());
    for (int it = 0; it < 40 && (phase == 1 || phase == 2); it++) begin
      if (phase == 1) fire_a(att_a | pick_bit(ship_b & ~att_a));
      else            fire_b(att_b | pick_bit(~ship_a & ~att_b));
    end
    check("g3_winner", 32'(phase), 32'd3);
    check_disp("g3_end");

    cyc();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
